// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter: widths, FSM state
// encodings, access size codes and the size-to-byte-count helper.
package mem_arbiter_pkg;

   localparam int Addrlen = 32;
   localparam int Instlen = 32;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_IF_RD  = 2'd1,
      ARB_MEM_RD = 2'd2,
      ARB_MEM_WR = 2'd3
   } arb_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // Size code 3 is not a legal RISC-V width; it is served as a full word.
   function automatic logic [2:0] byteCount(input logic [1:0] size);
      case (size)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the arbiter: byte counter, base+cnt address generation,
// little-endian read assembly and write byte selection.
module mem_byte_seq
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = Addrlen,
   parameter int DATA_W = Instlen
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [2:0]        count_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              step_i,
   input  logic              capture_i,
   input  logic [7:0]        ramDin_i,
   output logic [2:0]        cnt_o,
   output logic [2:0]        count_o,
   output logic [DATA_W-1:0] assembled_o,
   output logic [ADDR_W-1:0] ramA_o,
   output logic [7:0]        ramDout_o
);

   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        count_q, count_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [ADDR_W-1:0] ramA_q, ramA_d;
   logic [7:0]        ramDout_q, ramDout_d;
   logic [2:0]        nextIdx;
   logic [1:0]        prevIdx;
   logic [DATA_W-1:0] assembled;

   // The byte arriving now belongs to the address issued one step earlier.
   always_comb begin
      nextIdx   = cnt_q + 3'd1;
      prevIdx   = cnt_q[1:0] - 2'd1;
      assembled = asm_q;
      assembled[{prevIdx, 3'b000} +: 8] = ramDin_i;

      cnt_d     = cnt_q;
      count_d   = count_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      asm_d     = asm_q;
      ramA_d    = ramA_q;
      ramDout_d = ramDout_q;

      if (start_i) begin
         cnt_d     = 3'd0;
         count_d   = count_i;
         base_d    = base_i;
         wdata_d   = wdata_i;
         asm_d     = '0;
         ramA_d    = base_i;
         ramDout_d = wdata_i[7:0];
      end else if (step_i) begin
         cnt_d = nextIdx;
         if (nextIdx < count_q) begin
            ramA_d    = base_q + {{(ADDR_W-3){1'b0}}, nextIdx};
            ramDout_d = wdata_q[{nextIdx[1:0], 3'b000} +: 8];
         end
      end

      if (capture_i) begin
         asm_d = assembled;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= 3'd0;
         count_q   <= 3'd0;
         base_q    <= '0;
         wdata_q   <= '0;
         asm_q     <= '0;
         ramA_q    <= '0;
         ramDout_q <= 8'h00;
      end else begin
         cnt_q     <= cnt_d;
         count_q   <= count_d;
         base_q    <= base_d;
         wdata_q   <= wdata_d;
         asm_q     <= asm_d;
         ramA_q    <= ramA_d;
         ramDout_q <= ramDout_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign count_o     = count_q;
   assign assembled_o = assembled;
   assign ramA_o      = ramA_q;
   assign ramDout_o   = ramDout_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM between instruction fetch and the MEM stage.
// Optional MEM_ARB_IO_WAIT_EN holds IO stores while the UART buffer is full.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = Addrlen,
   parameter int DATA_W = Instlen
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic              if_done_o,
   output logic [DATA_W-1:0] if_inst_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_size_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic              mem_done_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i,
   input  logic              io_full_i
);

   arb_state_e        state_q, state_d;
   logic              ramWr_q, ramWr_d;
   logic              ifDone_q, ifDone_d;
   logic              memDone_q, memDone_d;
   logic [DATA_W-1:0] ifInst_q, ifInst_d;
   logic [DATA_W-1:0] memRdata_q, memRdata_d;

   logic              seqStart, seqStep, seqCapture;
   logic [ADDR_W-1:0] seqBase;
   logic [2:0]        seqCount;
   logic [2:0]        seqCnt, seqN;
   logic [DATA_W-1:0] seqAssembled;
   logic              ioWait;
   logic              turnaround;

`ifdef MEM_ARB_IO_WAIT_EN
   assign ioWait = mem_we_i && (mem_addr_i[17:16] == 2'b11) && io_full_i;
`else
   logic unusedIoFull;
   assign unusedIoFull = io_full_i;
   assign ioWait       = 1'b0;
`endif

   assign turnaround = ifDone_q | memDone_q;

   mem_byte_seq #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .start_i    (seqStart),
      .base_i     (seqBase),
      .count_i    (seqCount),
      .wdata_i    (mem_wdata_i),
      .step_i     (seqStep),
      .capture_i  (seqCapture),
      .ramDin_i   (ram_din_i),
      .cnt_o      (seqCnt),
      .count_o    (seqN),
      .assembled_o(seqAssembled),
      .ramA_o     (ram_a_o),
      .ramDout_o  (ram_dout_o)
   );

   // A blocked MEM request still outranks fetch, so a held IO store stalls new fetches.
   always_comb begin
      state_d    = state_q;
      ramWr_d    = 1'b0;
      ifDone_d   = 1'b0;
      memDone_d  = 1'b0;
      ifInst_d   = ifInst_q;
      memRdata_d = memRdata_q;
      seqStart   = 1'b0;
      seqStep    = 1'b0;
      seqCapture = 1'b0;
      seqBase    = mem_addr_i;
      seqCount   = byteCount(mem_size_i);

      case (state_q)
         ARB_IDLE: begin
            if (!turnaround) begin
               if (mem_req_i && !ioWait) begin
                  seqStart = 1'b1;
                  ramWr_d  = mem_we_i;
                  state_d  = mem_we_i ? ARB_MEM_WR : ARB_MEM_RD;
               end else if (if_req_i && !mem_req_i && !if_flush_i) begin
                  seqStart = 1'b1;
                  seqBase  = if_addr_i;
                  seqCount = 3'd4;
                  state_d  = ARB_IF_RD;
               end
            end
         end
         ARB_IF_RD: begin
            if (if_flush_i) begin
               state_d = ARB_IDLE;
            end else if (seqCnt == seqN) begin
               ifInst_d = seqAssembled;
               ifDone_d = 1'b1;
               state_d  = ARB_IDLE;
            end else begin
               seqStep    = 1'b1;
               seqCapture = (seqCnt != 3'd0);
            end
         end
         ARB_MEM_RD: begin
            if (seqCnt == seqN) begin
               memRdata_d = seqAssembled;
               memDone_d  = 1'b1;
               state_d    = ARB_IDLE;
            end else begin
               seqStep    = 1'b1;
               seqCapture = (seqCnt != 3'd0);
            end
         end
         ARB_MEM_WR: begin
            if (seqCnt + 3'd1 == seqN) begin
               memDone_d = 1'b1;
               state_d   = ARB_IDLE;
            end else begin
               seqStep = 1'b1;
               ramWr_d = 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         ramWr_q    <= 1'b0;
         ifDone_q   <= 1'b0;
         memDone_q  <= 1'b0;
         ifInst_q   <= ZeroWord;
         memRdata_q <= ZeroWord;
      end else begin
         state_q    <= state_d;
         ramWr_q    <= ramWr_d;
         ifDone_q   <= ifDone_d;
         memDone_q  <= memDone_d;
         ifInst_q   <= ifInst_d;
         memRdata_q <= memRdata_d;
      end
   end

   assign ram_wr_o    = ramWr_q;
   assign if_done_o   = ifDone_q;
   assign mem_done_o  = memDone_q;
   assign if_inst_o   = ifInst_q;
   assign mem_rdata_o = memRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model, scoreboard queues for
// RAM writes and done pulses, a vector table plus hand-written corner sequences.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic        if_req, if_flush, if_done;
   logic [31:0] if_addr, if_inst;
   logic        mem_req, mem_we, mem_done;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout, ram_din;
   logic        io_full;

   int cyc = 0;
   int checkCount = 0;
   int passCount = 0;
   bit monEn = 0;

   typedef struct {
      bit          isMem;
      bit          checkData;
      logic [31:0] data;
   } done_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      bit          isFetch;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      int          latency;
   } vec_t;

   done_t doneQ[$];
   wr_t   wrQ[$];
   vec_t  vecs[13];
   logic [7:0] ram [logic [31:0]];

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_flush_i (if_flush),
      .if_done_o  (if_done),
      .if_inst_o  (if_inst),
      .mem_req_i  (mem_req),
      .mem_we_i   (mem_we),
      .mem_size_i (mem_size),
      .mem_addr_i (mem_addr),
      .mem_wdata_i(mem_wdata),
      .mem_done_o (mem_done),
      .mem_rdata_o(mem_rdata),
      .ram_a_o    (ram_a),
      .ram_wr_o   (ram_wr),
      .ram_dout_o (ram_dout),
      .ram_din_i  (ram_din),
      .io_full_i  (io_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rdRam(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   // RAM model: read data appears one cycle after its address.
   always @(posedge clk) begin
      ram_din <= rdRam(ram_a);
      if (ram_wr === 1'b1) ram[ram_a] = ram_dout;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Every write strobe and done pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (monEn) begin
         if (ram_wr === 1'b1) begin
            if (wrQ.size() == 0) begin
               checkOutput("unexpected write", {31'b0, ram_wr}, 32'h0);
            end else begin
               wr_t w;
               w = wrQ.pop_front();
               checkOutput("write addr", ram_a, w.addr);
               checkOutput("write byte", {24'h0, ram_dout}, {24'h0, w.data});
            end
         end
         if (if_done === 1'b1 || mem_done === 1'b1) begin
            if (doneQ.size() == 0) begin
               checkOutput("unexpected done", {30'b0, if_done, mem_done}, 32'h0);
            end else begin
               done_t d;
               d = doneQ.pop_front();
               checkOutput("done source", {30'b0, if_done, mem_done},
                           d.isMem ? 32'h1 : 32'h2);
               if (d.checkData)
                  checkOutput("done data", d.isMem ? mem_rdata : if_inst, d.data);
            end
         end
      end
   end

   task automatic waitDone(input bit wantMem, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((wantMem ? mem_done : if_done) === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) checkOutput("done timeout", {31'b0, wantMem ? mem_done : if_done}, 32'h1);
   endtask

   task automatic pushStore(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size);
      int nb;
      nb = (size == SIZE_B) ? 1 : (size == SIZE_H) ? 2 : 4;
      for (int k = 0; k < nb; k++) wrQ.push_back(wr_t'{addr + k, wdata[8*k +: 8]});
   endtask

   task automatic applyStimulus(input vec_t v);
      int t, at;
      t = cyc;
      if (v.isFetch) begin
         if_req  = 1'b1;
         if_addr = v.addr;
         doneQ.push_back(done_t'{1'b0, 1'b1, v.expData});
      end else begin
         mem_req   = 1'b1;
         mem_we    = v.we;
         mem_size  = v.size;
         mem_addr  = v.addr;
         mem_wdata = v.wdata;
         doneQ.push_back(done_t'{1'b1, !v.we, v.expData});
         if (v.we) pushStore(v.addr, v.wdata, v.size);
      end
      waitDone(!v.isFetch, 20, at);
      checkOutput("latency", at - t, v.latency);
      if_req  = 1'b0;
      mem_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t, at, md, f;
      bit found;

      rst = 1'b1; if_req = 0; if_flush = 0; if_addr = 0;
      mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0; io_full = 0;

      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
      ram[32'h1000] = 8'hEF; ram[32'h1001] = 8'hBE; ram[32'h1002] = 8'hAD;
      ram[32'h1003] = 8'hDE; ram[32'h1004] = 8'h77;
      ram[32'h0] = 8'h93; ram[32'h1] = 8'h00; ram[32'h2] = 8'h10; ram[32'h3] = 8'h00;
      ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22;
      ram[32'h200] = 8'h6F; ram[32'h201] = 8'h00; ram[32'h202] = 8'h00; ram[32'h203] = 8'h00;
      ram[32'h400] = 8'h67; ram[32'h401] = 8'h80; ram[32'h402] = 8'h00; ram[32'h403] = 8'h00;

      vecs[0]  = '{1'b1, 1'b0, SIZE_W, 32'h0000_0100, 32'h0, 32'h0000_0513, 6};
      vecs[1]  = '{1'b0, 1'b0, SIZE_W, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 6};
      vecs[2]  = '{1'b0, 1'b0, SIZE_B, 32'h0000_1001, 32'h0, 32'h0000_00BE, 3};
      vecs[3]  = '{1'b0, 1'b0, SIZE_H, 32'h0000_1002, 32'h0, 32'h0000_DEAD, 4};
      vecs[4]  = '{1'b1, 1'b0, SIZE_W, 32'h0000_1001, 32'h0, 32'h77DE_ADBE, 6};
      vecs[5]  = '{1'b0, 1'b1, SIZE_H, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3};
      vecs[6]  = '{1'b0, 1'b0, SIZE_W, 32'h0000_2000, 32'h0, 32'hABCD_2211, 6};
      vecs[7]  = '{1'b0, 1'b1, SIZE_W, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 5};
      vecs[8]  = '{1'b0, 1'b0, 2'd3,   32'h0000_3004, 32'h0, 32'hCAFE_F00D, 6};
      vecs[9]  = '{1'b0, 1'b1, SIZE_H, 32'hFFFF_FFFF, 32'h0000_5AA5, 32'h0, 3};
      vecs[10] = '{1'b0, 1'b0, SIZE_H, 32'hFFFF_FFFF, 32'h0, 32'h0000_5AA5, 4};
      vecs[11] = '{1'b0, 1'b1, SIZE_B, 32'h0000_3006, 32'hFFFF_FF99, 32'h0, 2};
      vecs[12] = '{1'b0, 1'b0, SIZE_W, 32'h0000_3004, 32'h0, 32'hCA99_F00D, 6};

      repeat (3) @(negedge clk);
      checkOutput("reset ram_a", ram_a, 32'h0);
      checkOutput("reset ram_wr", {31'b0, ram_wr}, 32'h0);
      checkOutput("reset ram_dout", {24'h0, ram_dout}, 32'h0);
      checkOutput("reset dones", {30'b0, if_done, mem_done}, 32'h0);
      checkOutput("reset if_inst", if_inst, 32'h0);
      checkOutput("reset mem_rdata", mem_rdata, 32'h0);
      rst = 1'b0;
      monEn = 1'b1;
      @(negedge clk);

      $display("[TB] word fetch address sequence");
      t = cyc;
      if_req = 1'b1; if_addr = 32'h100;
      doneQ.push_back(done_t'{1'b0, 1'b1, 32'h0000_0513});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("fetch addr", ram_a, 32'h100 + k);
      end
      waitDone(1'b0, 10, at);
      checkOutput("fetch latency", at - t, 6);
      if_req = 1'b0;
      @(negedge clk);

      $display("[TB] simultaneous requests");
      t = cyc;
      if_req = 1'b1; if_addr = 32'h0;
      mem_req = 1'b1; mem_we = 1'b0; mem_size = SIZE_W; mem_addr = 32'h1000;
      doneQ.push_back(done_t'{1'b1, 1'b1, 32'hDEAD_BEEF});
      doneQ.push_back(done_t'{1'b0, 1'b1, 32'h0010_0093});
      waitDone(1'b1, 20, md);
      checkOutput("mem first latency", md - t, 6);
      mem_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("fetch addr after mem", ram_a, 32'h0);
      waitDone(1'b0, 20, at);
      checkOutput("fetch after mem done", at - md, 7);
      if_req = 1'b0;
      @(negedge clk);

      $display("[TB] fetch flush");
      t = cyc;
      found = 1'b0;
      if_req = 1'b1; if_addr = 32'h200;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ram_a === 32'h202) begin
            found = 1'b1;
            break;
         end
      end
      f = cyc;
      checkOutput("flush point cycle", found ? f - t : -1, 3);
      if_flush = 1'b1;
      @(negedge clk);
      checkOutput("flush no done", {31'b0, if_done}, 32'h0);
      checkOutput("flush keeps if_inst", if_inst, 32'h0010_0093);
      if_flush = 1'b0; if_addr = 32'h400;
      doneQ.push_back(done_t'{1'b0, 1'b1, 32'h0000_8067});
      waitDone(1'b0, 20, at);
      checkOutput("fetch after flush", at - f, 7);
      if_req = 1'b0;
      @(negedge clk);

      $display("[TB] vector table");
      for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

      $display("[TB] reset during store");
      t = cyc;
      mem_req = 1'b1; mem_we = 1'b1; mem_size = SIZE_W;
      mem_addr = 32'h5000; mem_wdata = 32'h4433_2211;
      wrQ.push_back(wr_t'{32'h5000, 8'h11});
      wrQ.push_back(wr_t'{32'h5001, 8'h22});
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("rst ram_wr", {31'b0, ram_wr}, 32'h0);
      checkOutput("rst ram_a", ram_a, 32'h0);
      checkOutput("rst ram_dout", {24'h0, ram_dout}, 32'h0);
      checkOutput("rst mem_done", {31'b0, mem_done}, 32'h0);
      checkOutput("rst if_inst", if_inst, 32'h0);
      checkOutput("rst mem_rdata", mem_rdata, 32'h0);
      mem_req = 1'b0;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("rst byte1 written", {24'h0, rdRam(32'h5001)}, 32'h22);
      checkOutput("rst byte2 untouched", {24'h0, rdRam(32'h5002)}, 32'h0);

      $display("[TB] IO store with buffer full");
      t = cyc;
      io_full = 1'b1;
      mem_req = 1'b1; mem_we = 1'b1; mem_size = SIZE_B;
      mem_addr = 32'h0003_0000; mem_wdata = 32'h0000_00C3;
      doneQ.push_back(done_t'{1'b1, 1'b0, 32'h0});
      wrQ.push_back(wr_t'{32'h0003_0000, 8'hC3});
      fork
         begin
            repeat (5) @(negedge clk);
            io_full = 1'b0;
         end
      join_none
      waitDone(1'b1, 20, at);
`ifdef MEM_ARB_IO_WAIT_EN
      checkOutput("io store latency", at - t, 7);
`else
      checkOutput("io store latency", at - t, 2);
`endif
      mem_req = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("io byte stored", {24'h0, rdRam(32'h0003_0000)}, 32'hC3);

      checkOutput("write queue drained", wrQ.size(), 32'h0);
      checkOutput("done queue drained", doneQ.size(), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-wide RAM port between the instruction-fetch stage and the MEM stage of the 5-stage RISC-V pipeline. It serialises 32-bit fetches and 1/2/4-byte loads and stores into per-byte RAM cycles, and returns one-cycle completion pulses. Stage requesters hold their request until done; the pipeline stall controller uses the pending requests to freeze the IF/ID and later stage registers.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, requester data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address
- if_flush  in  1  jump/branch redirect; aborts an in-flight fetch
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched instruction
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- mem_addr  in  32  data address
- mem_wdata  in  32  store data, little-endian
- mem_done  out  1  one-cycle pulse, mem_rdata valid for loads
- mem_rdata  out  32  load data, zero-extended; sign extension is done in the MEM stage
- ram_a  out  32  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid one cycle after its address
- io_full  in  1  UART buffer full (used only with MEM_ARB_IO_WAIT_EN)

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE priority: mem_req first (older instruction), then if_req. A fetch with if_flush high is not accepted.
- Byte count n: fetch = 4; mem = 1, 2 or 4 per mem_size.
- A 3-bit byte counter cnt issues address base+cnt. Received bytes are assembled little-endian into a 32-bit shift/assembly register.
- Reads (IF_RD, MEM_RD):
  - The address for byte k is driven in cycle k.
  - ram_din is captured in cycle k+1.
  - After byte n-1 is captured: done pulse, return to IDLE.
- Writes (MEM_WR):
  - ram_wr = 1 with ram_dout = byte k of mem_wdata at base+k, for k = 0..n-1.
  - Done pulse after the last byte; ram_wr returns to 0.
- if_flush in IF_RD: abort at the next edge, go to IDLE, no if_done, if_inst unchanged. if_flush never affects MEM_RD or MEM_WR.
- Turnaround: in the cycle either done is high, the FSM is in IDLE and ignores all requests. Requesters drop or renew their request by the following cycle.
- Reset mid-transaction: discarded immediately; no done pulse.
- Address arithmetic: base + cnt, 32-bit wrap. Misaligned accesses are allowed and are not checked.

## Timing
- Reset values: state IDLE, cnt 0, ram_a 0, ram_wr 0, ram_dout 0, if_done 0, mem_done 0, if_inst 0, mem_rdata 0.
- All outputs are registered.
- Request first seen in IDLE at cycle T:
  - First address at T+1.
  - Read of n bytes: done at T+n+2 (word read: T+6).
  - Write of n bytes: ram_wr high T+1..T+n, done at T+n+1.
- Back-to-back: with a request still held, the next acceptance happens at done+1, so its first address is at done+2.
- Simultaneous mem_req and if_req in IDLE: MEM is served; the fetch starts at MEM done+1.

## Configuration
- MEM_ARB_IO_WAIT_EN:
  - Defined: a store with mem_addr[17:16] == 2'b11 waits in IDLE while io_full = 1. It is accepted in the first cycle io_full = 0. A pending fetch may be served meanwhile only if it was already accepted; MEM priority is kept, so a waiting store blocks new fetches.
  - Undefined: io_full is ignored and IO stores proceed immediately.

## Structure
- Shared config package/header holds:
  - Width defines: Addrlen, Instlen, ZeroWord.
  - State encodings: ARB_IDLE, ARB_IF_RD, ARB_MEM_RD, ARB_MEM_WR.
  - Size codes: SIZE_B, SIZE_H, SIZE_W.
- One natural sub-module, mem_byte_seq: counter, address generation, byte assembly and byte select. The arbiter FSM instantiates it and drives base, n and direction.

## Test plan
- Word fetch: if_req, if_addr = 0x100, RAM bytes 13 05 00 00 -> ram_a 0x100..0x103 at T+1..T+4; if_done at T+6 with if_inst = 0x00000513.
- Simultaneous requests: if_req (0x0) and mem_req load word at 0x1000 holding 0xDEADBEEF -> mem_done first with 0xDEADBEEF; fetch address 0x0 first driven at mem_done+2.
- Half store: mem_we = 1, size 1, addr 0x2002, wdata 0x1234ABCD -> ram_wr at 0x2002 = 0xCD, then 0x2003 = 0xAB; mem_done at T+3; no further writes.
- Flush: if_flush asserted while ram_a = 0x202 of a fetch from 0x200 -> IDLE next cycle, no if_done; a new fetch at 0x400 completes normally.
- Reset mid-store: rst asserted after 2 of 4 bytes written -> ram_wr = 0 and all outputs at reset values the next cycle; no mem_done.
- IO wait (MEM_ARB_IO_WAIT_EN): store byte to 0x30000 with io_full = 1 for 5 cycles -> no ram_wr until io_full falls; write 0x30000 at the next cycle + 1; mem_done one cycle later.
